// File: rtl/alu_exec.sv
// Iterative EX-stage execute unit: single-cycle logic/arith/compare ops,
// 1-bit-per-cycle shifter for SLL/SRL/SRA, valid/ready on both sides.
package alu_exec_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_operation_type;
endpackage

// Handshakes: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready. kill masks both ready/valid.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_operation_type op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              kill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [1:0]      kind_q, kind_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic [1:0]      op_kind;
  logic [XLEN-1:0] simple_res;
  logic [XLEN-1:0] acc_shifted;

  assign shamt = b[SHW-1:0];

  always_comb begin
    is_shift = 1'b0;
    op_kind  = K_SLL;
    case (op)
      ALU_SLL: begin is_shift = 1'b1; op_kind = K_SLL; end
      ALU_SRL: begin is_shift = 1'b1; op_kind = K_SRL; end
      ALU_SRA: begin is_shift = 1'b1; op_kind = K_SRA; end
      default: begin is_shift = 1'b0; op_kind = K_SLL; end
    endcase
  end

  // Single-cycle datapath; encodings outside the enum yield zero.
  always_comb begin
    simple_res = '0;
    case (op)
      ALU_ADD:  simple_res = a + b;
      ALU_SUB:  simple_res = a - b;
      ALU_XOR:  simple_res = a ^ b;
      ALU_OR:   simple_res = a | b;
      ALU_AND:  simple_res = a & b;
      ALU_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: simple_res = {{(XLEN-1){1'b0}}, (a < b)};
      default:  simple_res = '0;
    endcase
  end

  always_comb begin
    acc_shifted = acc_q;
    case (kind_q)
      K_SLL:   acc_shifted = {acc_q[XLEN-2:0], 1'b0};
      K_SRL:   acc_shifted = {1'b0, acc_q[XLEN-1:1]};
      K_SRA:   acc_shifted = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: acc_shifted = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    kind_d   = kind_q;
    result_d = result_q;
    if (kill) begin
      // Flush: drop the operation, result register keeps its old value.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (!is_shift) begin
              result_d = simple_res;
              state_d  = S_DONE;
            end else if (shamt == '0) begin
              result_d = a;
              state_d  = S_DONE;
            end else begin
              acc_d   = a;
              cnt_d   = shamt;
              kind_d  = op_kind;
              state_d = S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc_d = acc_shifted;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_d = acc_shifted;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      kind_q   <= K_SLL;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      kind_q   <= kind_d;
      result_q <= result_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !kill;
  assign out_valid   = (state_q == S_DONE) && !kill;
  assign result      = result_q;
  assign zero        = (result_q == '0);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, random ops against
// a behavioural model, and hand-written backpressure/kill/reset sequences.
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  alu_operation_type op;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              kill;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              zero;
  logic              busy;
  logic [1:0]        dbg_state;

  int n_vec;
  int n_fail;
  int n_checks;
  logic [31:0] exp_q[$];

  alu_exec #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    int unsigned sh;
    sh = y % 32;
    case (o)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x << sh;
      4'd3: return x >> sh;
      4'd4: return $unsigned($signed(x) >>> sh);
      4'd5: return x ^ y;
      4'd6: return x | y;
      4'd7: return x & y;
      4'd8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] o, input logic [31:0] y);
    if ((o == 4'd2 || o == 4'd3 || o == 4'd4) && (y % 32) != 0) return 1 + int'(y % 32);
    return 1;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called on a negedge with the unit idle; returns on a negedge with the unit idle.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat);
    int cycles;
    logic busy_ok;
    logic [31:0] exp_v;
    n_vec++;
    chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op = alu_operation_type'(o);
    a = x;
    b = y;
    exp_q.push_back(exp_res);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    cycles = 1;
    busy_ok = 1'b1;
    while (!out_valid && cycles < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cycles++;
    end
    chk({name, ".latency"}, 32'(cycles), 32'(exp_lat));
    chk({name, ".busy"}, 32'(busy_ok), 32'd1);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk({name, ".result"}, result, exp_v);
    chk({name, ".zero"}, 32'(zero), 32'(exp_v == 32'd0));
    @(negedge clk);
    chk({name, ".idle_after"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int   idle_cnt;
    logic ok_v, ok_r, ok_ir, no_ov;
    logic [3:0] ro;
    logic [31:0] ra, rb;

    n_vec = 0; n_fail = 0; n_checks = 0;
    tbl[0]  = '{"add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1};
    tbl[1]  = '{"sub_zero", 4'd1, 32'd5,        32'd5,         32'h0000_0000, 1};
    tbl[2]  = '{"slt",      4'd8, 32'hFFFF_FFFF, 32'd1,        32'd1,         1};
    tbl[3]  = '{"sltu",     4'd9, 32'hFFFF_FFFF, 32'd1,        32'd0,         1};
    tbl[4]  = '{"and",      4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1};
    tbl[5]  = '{"or",       4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1};
    tbl[6]  = '{"xor",      4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1};
    tbl[7]  = '{"sra31",    4'd4, 32'h8000_0000, 32'd31,       32'hFFFF_FFFF, 32};
    tbl[8]  = '{"srl31",    4'd3, 32'h8000_0000, 32'd31,       32'h0000_0001, 32};
    tbl[9]  = '{"sll_sh0",  4'd2, 32'd1,        32'h20,        32'd1,         1};
    tbl[10] = '{"bad_op",   4'd12, 32'd3,       32'd4,         32'd0,         1};
    tbl[11] = '{"sll4",     4'd2, 32'd3,        32'hFFFF_FFE4, 32'h0000_0030, 5};

    rst = 1'b1; in_valid = 1'b0; op = ALU_ADD; a = '0; b = '0;
    kill = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst.result", result, 32'd0);
    chk("rst.zero", 32'(zero), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++)
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

    // Randomized against the model
    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 11));
      if (ro > 4'd9) ro = 4'($urandom_range(10, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op("rand", ro, ra, rb, ref_result(ro, ra, rb), ref_latency(ro, rb));
    end

    // Backpressure: DONE holds with out_ready low
    out_ready = 1'b0;
    n_vec++;
    in_valid = 1'b1; op = ALU_ADD; a = 32'd1; b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    ok_v = 1'b1; ok_r = 1'b1; ok_ir = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1) ok_v = 1'b0;
      if (result !== 32'd3) ok_r = 1'b0;
      if (in_ready !== 1'b0) ok_ir = 1'b0;
      @(negedge clk);
    end
    chk("bp.out_valid_held", 32'(ok_v), 32'd1);
    chk("bp.result_stable", 32'(ok_r), 32'd1);
    chk("bp.in_ready_low", 32'(ok_ir), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.in_ready_after", 32'(in_ready), 32'd1);
    chk("bp.out_valid_after", 32'(out_valid), 32'd0);

    // Kill on the 3rd SHIFT cycle
    run_op("pre_kill", 4'd0, 32'd2, 32'd2, 32'd4, 1);
    n_vec++;
    in_valid = 1'b1; op = ALU_SLL; a = 32'd1; b = 32'd8;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("kill.busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    #1;
    chk("kill.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    kill = 1'b0;
    chk("kill.idle", 32'(busy), 32'd0);
    no_ov = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) no_ov = 1'b0;
      @(negedge clk);
    end
    chk("kill.no_out_valid", 32'(no_ov), 32'd1);
    chk("kill.result_kept", result, 32'd4);

    // Kill together with in_valid in IDLE
    n_vec++;
    kill = 1'b1; in_valid = 1'b1; op = ALU_ADD; a = 32'd9; b = 32'd9;
    #1;
    chk("killiv.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    kill = 1'b0; in_valid = 1'b0;
    chk("killiv.busy", 32'(busy), 32'd0);
    idle_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (!out_valid && !busy) idle_cnt++;
      @(negedge clk);
    end
    chk("killiv.stays_idle", 32'(idle_cnt), 32'd3);

    // Reset mid-SHIFT
    n_vec++;
    in_valid = 1'b1; op = ALU_SRL; a = 32'h8000_0000; b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid.busy_before", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid.out_valid", 32'(out_valid), 32'd0);
    chk("rstmid.result", result, 32'd0);
    chk("rstmid.zero", 32'(zero), 32'd1);
    chk("rstmid.busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    run_op("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 1);

    chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Iterative execute unit that consumes the `alu_operation_type` code produced by the ALU control decode and performs the operation on two XLEN-bit operands. Logic, add/sub and compare operations complete in one cycle. Shifts use a 1-bit-per-cycle shifter to save area. The block sits in the EX stage between operand select and writeback, and uses valid/ready handshakes on both input and output so the pipeline can stall on long shifts.

## Interface
- `XLEN`, 32, operand/result width; must be a power of two ≥ 8.
- `SHW`, `$clog2(XLEN)`, shift-amount width; derived, not overridden.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request.
- `op`  in  `alu_operation_type`  ADD, SUB, SLL, SRL, SRA, XOR, OR, AND, SLT, SLTU.
- `a`  in  XLEN  operand A (rs1).
- `b`  in  XLEN  operand B (rs2 or immediate).
- `kill`  in  1  synchronous abort of the in-flight operation (pipeline flush).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  registered result.
- `zero`  out  1  `result == 0`.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- `in_ready = (state==IDLE) && !kill`. Accept occurs when `in_valid && in_ready`; `op`, `a` and `b` are sampled only on accept.
- IDLE, accept, non-shift op: compute the result into the `result` register and go to DONE.
  - ADD/SUB wrap modulo 2^XLEN.
  - XOR/OR/AND are bitwise.
  - SLT is a signed compare; SLTU is unsigned. The compare result is 0 or 1, zero-extended.
  - Any encoding outside the enum gives result 0 and goes to DONE.
- IDLE, accept, shift op (SLL/SRL/SRA), `shamt = b[SHW-1:0]`; upper bits of `b` are ignored:
  - If `shamt==0`: `result <= a`, go to DONE.
  - Otherwise: load the accumulator with `a` and the counter with `shamt`, latch the shift kind, go to SHIFT.
- SHIFT, each cycle: shift the accumulator by 1 and decrement the counter.
  - SLL fills with 0; SRL fills MSB with 0; SRA replicates the MSB.
  - On the shift where the counter goes from 1 to 0: write the shifted value to `result` and go to DONE.
- DONE:
  - `out_valid = (state==DONE) && !kill`.
  - `result` stays stable until handshake.
  - On `out_valid && out_ready`, go to IDLE.
- `kill` has priority over everything except `rst`. In any state it forces IDLE on the next edge and discards the operation. `result` keeps its last value, but `out_valid` is never raised for the killed operation.
- `zero` is combinational from the `result` register.
- `busy = (state != IDLE)`.

## Timing
- Reset values, applied asynchronously and immediately: state IDLE, `result=0`, `zero=1`, `out_valid=0`, `busy=0`, `in_ready=1` (when `kill=0`), counter and accumulator cleared.
- Latency, with the accept in cycle N:
  - Non-shift ops, and shifts with `shamt==0`: `out_valid` in cycle N+1.
  - Shifts with `shamt≥1`: `out_valid` in cycle N+1+shamt. The worst case is N+XLEN for `shamt=XLEN-1`.
- Throughput: at most one operation per 2 cycles, because `in_ready` is 0 in DONE even when `out_ready=1`.
- Backpressure: with `out_ready=0`, DONE holds indefinitely and `result` does not change.
- Simultaneous `kill` and `in_valid` in IDLE: no accept, and the unit stays in IDLE.
- Simultaneous `kill` and `out_ready` in DONE: no transfer, because `out_valid` is 0.
- `rst` during SHIFT or DONE: the operation is lost and outputs take their reset values immediately. No result is produced for it.

## Test plan
- Reset, then ADD with `a=0x7FFF_FFFF`, `b=1` -> `out_valid` one cycle after accept, `result=0x8000_0000`, `zero=0`. Next, SUB with `a=5`, `b=5` -> `result=0`, `zero=1`.
- SLT with `a=0xFFFF_FFFF`, `b=1` -> `result=1`. SLTU with the same operands -> `result=0`. AND/OR/XOR with `a=0xF0F0_F0F0`, `b=0xFF00_FF00` -> `0xF000_F000` / `0xFFF0_FFF0` / `0x0FF0_0FF0`.
- SRA with `a=0x8000_0000`, `b=31` -> `out_valid` 32 cycles after accept, `result=0xFFFF_FFFF`, `busy=1` throughout. SRL with the same operands -> `0x0000_0001`. SLL with `a=1`, `b=0x20` (`shamt=0`) -> `result=1` one cycle after accept.
- Backpressure: hold `out_ready=0` for 10 cycles in DONE -> `out_valid` stays 1, `result` is stable, `in_ready=0`. Assert `out_ready` -> IDLE next cycle and `in_ready=1`.
- `kill` on the 3rd SHIFT cycle of SLL with `a=1`, `b=8` -> IDLE next cycle, no `out_valid` pulse, `result` unchanged from the previous operation. `kill` together with `in_valid` in IDLE -> no accept.
- `rst` pulsed mid-SHIFT -> immediately `out_valid=0`, `result=0`, `zero=1`, `busy=0`. A following ADD with `a=2`, `b=3` -> `result=5` after one cycle.
